cache_way_store: RTL and testbench

- Physical 4-way set-associative line store directly downstream of the cache controller.
- Holds 128 sets × 4 ways of {valid, dirty, age, tag, 512-bit data}.
- On read, returns all four candidate lines of a set. On write, commits a full line to the selected way(s) and rewrites the age fields of all four ways.
- Answers every accepted request with a one-cycle cache_ready pulse after a fixed latency.

---
 rtl/cache_pkg.sv | 39 +++
 rtl/cache_way_bank.sv | 74 +++++++
 rtl/cache_way_store.sv | 92 +++++++++
 tb/tb_cache_way_store.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared widths, line-field offsets and controller state encodings for the
// 4-way cache line store.
package cache_pkg;

  localparam int WORD_SIZE        = 32;
  localparam int SETS             = 128;
  localparam int SETS_BITS        = 7;
  localparam int AGE_BITS         = 2;
  localparam int TAG_BITS         = 21;
  localparam int BLOCK_DATA_WIDTH = 512;
  localparam int BANK             = 4;
  localparam int DEFAULT_LATENCY  = 2;

  // Line layout, MSB to LSB: valid, dirty, age, tag, data.
  localparam int LINE_W          = 1 + 1 + AGE_BITS + TAG_BITS + BLOCK_DATA_WIDTH;
  localparam int TAG_START       = BLOCK_DATA_WIDTH;
  localparam int AGE_START       = TAG_START + TAG_BITS;
  localparam int DIRTY_BIT_START = AGE_START + AGE_BITS;
  localparam int VALID_BIT_START = LINE_W - 1;

  typedef logic [LINE_W-1:0]    line_t;
  typedef logic [AGE_BITS-1:0]  age_t;
  typedef logic [SETS_BITS-1:0] index_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Returns the line with its age field replaced.
  function automatic line_t set_age(input line_t line, input age_t age);
    line_t l;
    l = line;
    l[AGE_START +: AGE_BITS] = age;
    return l;
  endfunction

endpackage

// File: rtl/cache_way_bank.sv
// One way of the line store: SETS entries, single write port, registered
// read that returns the post-write contents of the addressed set.
module cache_way_bank
  import cache_pkg::*;
#(
  parameter age_t RESET_AGE = '0
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  input  index_t addr,
  input  logic   line_we,
  input  logic   age_we,
  input  line_t  wline,
  input  age_t   wage,
  output line_t  rdata
);

  logic                        valid_q [SETS];
  logic                        dirty_q [SETS];
  age_t                        age_q   [SETS];
  logic [TAG_BITS-1:0]         tag_mem [SETS];
  logic [BLOCK_DATA_WIDTH-1:0] data_mem[SETS];
  line_t                       rdata_q;
  line_t                       cur_line;
  line_t                       next_line;

  // Assemble the stored line and what it becomes after this cycle's write.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    cur_line  = '0;
    cur_line[VALID_BIT_START]                      = valid_q[addr];
    cur_line[DIRTY_BIT_START]                      = dirty_q[addr];
    cur_line[AGE_START +: AGE_BITS]                = age_q[addr];
    cur_line[TAG_START +: TAG_BITS]                = tag_mem[addr];
    cur_line[BLOCK_DATA_WIDTH-1:0]                 = data_mem[addr];
    next_line = cur_line;
    if (line_we)     next_line = set_age(wline, wage);
    else if (age_we) next_line = set_age(cur_line, wage);
  end

  // Resettable metadata and the read register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SETS; i++) begin
        valid_q[i] <= 1'b0;
        dirty_q[i] <= 1'b0;
        age_q[i]   <= RESET_AGE;
      end
      rdata_q <= '0;
    end else if (en) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the values from before this edge.
      valid_q[addr] <= next_line[VALID_BIT_START];
      dirty_q[addr] <= next_line[DIRTY_BIT_START];
      age_q[addr]   <= next_line[AGE_START +: AGE_BITS];
      rdata_q       <= next_line;
    end
  end

  // Tag and data storage.
  // NOTE: the tag/data arrays carry no reset; a cleared valid bit makes their
  // contents irrelevant, and leaving them unreset lets them map onto RAM.
  always_ff @(posedge clk) begin
    if (en && line_we) begin
      tag_mem[addr]  <= wline[TAG_START +: TAG_BITS];
      data_mem[addr] <= wline[BLOCK_DATA_WIDTH-1:0];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/cache_way_store.sv
// 4-way set-associative line store. Accepts one request when idle, performs
// the read or write at acceptance, and answers with a one-cycle cache_ready
// pulse LATENCY cycles later.
module cache_way_store
  import cache_pkg::*;
#(
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SETS_BITS-1:0] cache_index,
  input  logic                 cache_enable,
  input  logic                 cache_rw,
  input  logic [BANK-1:0]      bank_selector,
  input  logic [LINE_W-1:0]    candidate_write,
  input  logic [AGE_BITS-1:0]  age_1,
  input  logic [AGE_BITS-1:0]  age_2,
  input  logic [AGE_BITS-1:0]  age_3,
  input  logic [AGE_BITS-1:0]  age_4,
  output logic [LINE_W-1:0]    candidate_1,
  output logic [LINE_W-1:0]    candidate_2,
  output logic [LINE_W-1:0]    candidate_3,
  output logic [LINE_W-1:0]    candidate_4,
  output logic                 cache_ready,
  output logic                 cache_busy
);

  // WAIT lasts LATENCY-1 cycles; the counter runs down to zero.
  localparam logic [3:0] WAIT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       accept;
  age_t       ages [BANK];
  line_t      cand [BANK];

  assign accept = (state_q == IDLE) && cache_enable;
  assign ages   = '{age_1, age_2, age_3, age_4};

  for (genvar k = 0; k < BANK; k++) begin : g_way
    cache_way_bank #(.RESET_AGE(age_t'(k))) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (accept),
      .addr    (cache_index),
      .line_we (cache_rw && bank_selector[k]),
      .age_we  (cache_rw),
      .wline   (candidate_write),
      .wage    (ages[k]),
      .rdata   (cand[k])
    );
  end

  // Next-state logic for the request/response sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (cache_enable) begin
        if (LATENCY > 1) begin
          state_d = WAIT;
          cnt_d   = WAIT_INIT;
        end else begin
          state_d = RESP;
        end
      end
      WAIT: if (cnt_q == 4'd0) state_d = RESP;
            else               cnt_d   = cnt_q - 4'd1;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cache_ready = (state_q == RESP);
  assign cache_busy  = (state_q != IDLE);
  assign candidate_1 = cand[0];
  assign candidate_2 = cand[1];
  assign candidate_3 = cand[2];
  assign candidate_4 = cand[3];

endmodule

// File: tb/tb_cache_way_store.sv
// Directed bench for cache_way_store: a LATENCY=2 instance and a LATENCY=1
// instance, a line-store model, and a response scoreboard.
module tb_cache_way_store;
  import cache_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [SETS_BITS-1:0] cache_index;
  logic                 cache_enable, en1, cache_rw;
  logic [BANK-1:0]      bank_selector;
  line_t                candidate_write;
  age_t                 age_1, age_2, age_3, age_4;
  line_t                c0_1, c0_2, c0_3, c0_4, c1_1, c1_2, c1_3, c1_4;
  logic                 ready0, busy0, ready1, busy1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [BANK-1:0][LINE_W-1:0] lines;
    logic [BANK-1:0]             full;
    int                          lat;
    string                       name;
  } exp_t;
  exp_t sb[$];

  line_t mline [BANK][SETS];
  bit    mwr   [BANK][SETS];

  cache_way_store #(.LATENCY(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .cache_index(cache_index), .cache_enable(cache_enable),
    .cache_rw(cache_rw), .bank_selector(bank_selector), .candidate_write(candidate_write),
    .age_1(age_1), .age_2(age_2), .age_3(age_3), .age_4(age_4),
    .candidate_1(c0_1), .candidate_2(c0_2), .candidate_3(c0_3), .candidate_4(c0_4),
    .cache_ready(ready0), .cache_busy(busy0));

  cache_way_store #(.LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cache_index(cache_index), .cache_enable(en1),
    .cache_rw(cache_rw), .bank_selector(bank_selector), .candidate_write(candidate_write),
    .age_1(age_1), .age_2(age_2), .age_3(age_3), .age_4(age_4),
    .candidate_1(c1_1), .candidate_2(c1_2), .candidate_3(c1_3), .candidate_4(c1_4),
    .cache_ready(ready1), .cache_busy(busy1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input line_t obs, input line_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic line_t cand(input int d, input int k);
    line_t c;
    c = '0;
    case (k)
      0: c = (d == 0) ? c0_1 : c1_1;
      1: c = (d == 0) ? c0_2 : c1_2;
      2: c = (d == 0) ? c0_3 : c1_3;
      default: c = (d == 0) ? c0_4 : c1_4;
    endcase
    return c;
  endfunction

  function automatic line_t meta_default(input int k);
    line_t l;
    l = '0;
    l[AGE_START +: AGE_BITS] = age_t'(k);
    return l;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < BANK; k++)
      for (int s = 0; s < SETS; s++) begin
        mline[k][s][VALID_BIT_START] = 1'b0;
        mline[k][s][DIRTY_BIT_START] = 1'b0;
        mline[k][s][AGE_START +: AGE_BITS] = age_t'(k);
      end
  endtask

  task automatic model_write(input int idx, input logic [BANK-1:0] mask, input line_t wl,
                             input logic [BANK-1:0][AGE_BITS-1:0] ages);
    for (int k = 0; k < BANK; k++) begin
      if (mask[k]) begin
        mline[k][idx] = set_age(wl, ages[k]);
        mwr[k][idx]   = 1'b1;
      end else begin
        mline[k][idx] = set_age(mline[k][idx], ages[k]);
      end
    end
  endtask

  // Pop the oldest expectation and compare it with the DUT outputs now.
  task automatic compare_resp(input int d, input int lat_obs);
    exp_t  e;
    line_t c;
    check("scoreboard_nonempty", line_t'(sb.size() > 0), line_t'(1));
    if (sb.size() == 0) return;
    e = sb.pop_front();
    if (e.lat > 0) check({e.name, " latency"}, line_t'(lat_obs), line_t'(e.lat));
    for (int k = 0; k < BANK; k++) begin
      c = cand(d, k);
      check($sformatf("%s way%0d meta", e.name, k + 1),
            line_t'(c[LINE_W-1:AGE_START]), line_t'(e.lines[k][LINE_W-1:AGE_START]));
      if (e.full[k])
        check($sformatf("%s way%0d line", e.name, k + 1), c, line_t'(e.lines[k]));
    end
  endtask

  // Issue one request from just after a rising edge and wait for its response.
  task automatic req(input int d, input int idx, input logic rw, input logic [BANK-1:0] mask,
                     input line_t wl, input logic [BANK-1:0][AGE_BITS-1:0] ages,
                     input int lat, input string name);
    exp_t e;
    int   start;
    bit   got;
    if (d == 0 && rw) model_write(idx, mask, wl, ages);
    for (int k = 0; k < BANK; k++) begin
      e.lines[k] = (d == 0) ? mline[k][idx] : meta_default(k);
      e.full[k]  = (d == 0) ? mwr[k][idx] : 1'b0;
    end
    e.lat = lat; e.name = name;
    sb.push_back(e);
    cache_index = index_t'(idx); cache_rw = rw; bank_selector = mask; candidate_write = wl;
    age_1 = ages[0]; age_2 = ages[1]; age_3 = ages[2]; age_4 = ages[3];
    if (d == 0) cache_enable = 1'b1; else en1 = 1'b1;
    start = cyc;
    @(posedge clk); #1;
    cache_enable = 1'b0; en1 = 1'b0;
    // Scramble the request inputs: they must already have been sampled.
    cache_index = ~cache_index; bank_selector = ~bank_selector; candidate_write = ~candidate_write;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if ((d == 0) ? ready0 : ready1) begin
        got = 1'b1;
        compare_resp(d, cyc - start);
      end
      @(posedge clk); #1;
    end
    check({name, " response_seen"}, line_t'(got), line_t'(1));
    if (!got) void'(sb.pop_front());
  endtask

  initial begin : stim
    line_t wl;
    logic [6:0] rpat, bpat;
    bit seen;

    rst_n = 1'b0; cache_enable = 1'b0; en1 = 1'b0; cache_rw = 1'b0; cache_index = '0;
    bank_selector = '0; candidate_write = '0; age_1 = '0; age_2 = '0; age_3 = '0; age_4 = '0;
    for (int k = 0; k < BANK; k++)
      for (int s = 0; s < SETS; s++) begin
        mline[k][s] = '0;
        mwr[k][s]   = 1'b0;
      end
    model_reset();

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", line_t'(ready0), line_t'(0));
    check("reset busy", line_t'(busy0), line_t'(0));
    for (int k = 0; k < BANK; k++) check($sformatf("reset cand%0d", k + 1), cand(0, k), '0);
    check("reset ready lat1", line_t'(ready1), line_t'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Read of a never-written set.
    req(0, 5, 1'b0, 4'b0000, '0, '{2'd0, 2'd0, 2'd0, 2'd0}, 2, "read5");

    // Write way 2 of set 9; the incoming age field is overridden by age_2.
    wl = '0;
    wl[VALID_BIT_START] = 1'b1;
    wl[DIRTY_BIT_START] = 1'b1;
    wl[AGE_START +: AGE_BITS] = 2'd3;
    wl[TAG_START +: TAG_BITS] = 21'h1ABCD;
    wl[BLOCK_DATA_WIDTH-1:0]  = {16{32'hDEADBEEF}};
    req(0, 9, 1'b1, 4'b0010, wl, '{2'd2, 2'd3, 2'd0, 2'd1}, 2, "write9");
    req(0, 9, 1'b0, 4'b0000, '0, '{2'd0, 2'd0, 2'd0, 2'd0}, 2, "read9");
    check("read9 way2 tag", line_t'(c0_2[TAG_START +: TAG_BITS]), line_t'(21'h1ABCD));
    req(0, 10, 1'b0, 4'b0000, '0, '{2'd0, 2'd0, 2'd0, 2'd0}, 2, "read10");

    // Enable held for six cycles: two accepted, responses three cycles apart.
    cache_index = 7'd9; cache_rw = 1'b0; bank_selector = '0;
    for (int r = 0; r < 2; r++) begin
      exp_t e;
      for (int k = 0; k < BANK; k++) begin
        e.lines[k] = mline[k][9];
        e.full[k]  = mwr[k][9];
      end
      e.lat = 0; e.name = $sformatf("hold%0d", r);
      sb.push_back(e);
    end
    cache_enable = 1'b1;
    rpat = '0; bpat = '0;
    for (int i = 0; i < 7; i++) begin
      if (i == 6) cache_enable = 1'b0;
      @(negedge clk);
      rpat[i] = ready0;
      bpat[i] = busy0;
      if (ready0) compare_resp(0, 0);
      @(posedge clk); #1;
    end
    check("hold ready pattern", line_t'(rpat), line_t'(7'b0100100));
    check("hold busy pattern", line_t'(bpat), line_t'(7'b0110110));
    check("hold responses drained", line_t'(sb.size()), line_t'(0));
    sb.delete();

    // Age-only write, then read back reversed ages with lines untouched.
    req(0, 9, 1'b1, 4'b0000, ~wl, '{2'd0, 2'd1, 2'd2, 2'd3}, 2, "agewrite9");
    req(0, 9, 1'b0, 4'b0000, '0, '{2'd0, 2'd0, 2'd0, 2'd0}, 2, "read9_ages");

    // Reset while a write is in WAIT: no response, set comes back invalid.
    model_write(20, 4'b0001, wl, '{2'd0, 2'd0, 2'd0, 2'd3});
    cache_index = 7'd20; cache_rw = 1'b1; bank_selector = 4'b0001; candidate_write = wl;
    age_1 = 2'd3; age_2 = 2'd0; age_3 = 2'd0; age_4 = 2'd0;
    cache_enable = 1'b1;
    @(posedge clk); #1;
    cache_enable = 1'b0;
    check("midreset busy before", line_t'(busy0), line_t'(1));
    rst_n = 1'b0;
    #1;
    check("midreset busy", line_t'(busy0), line_t'(0));
    check("midreset cand1", c0_1, '0);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); seen |= ready0;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); seen |= ready0;
    end
    @(posedge clk); #1;
    check("midreset no ready", line_t'(seen), line_t'(0));
    req(0, 20, 1'b0, 4'b0000, '0, '{2'd0, 2'd0, 2'd0, 2'd0}, 2, "read20");
    req(0, 9, 1'b0, 4'b0000, '0, '{2'd0, 2'd0, 2'd0, 2'd0}, 2, "read9_after_reset");

    // LATENCY=1 instance: candidates valid in the response cycle.
    req(1, 5, 1'b0, 4'b0000, '0, '{2'd0, 2'd0, 2'd0, 2'd0}, 1, "lat1_read5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
